// File: rtl/rr_arb_pkg.sv
// Shared arbiter types and helpers: FSM state encoding, default requester
// count, and a one-hot to index decoder reused by other arbiters.
package rr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int RR_ARB_DEFAULT_N = 4;

  // Highest set bit wins; callers only pass one-hot vectors up to 32 bits.
  function automatic int onehot_to_idx(input logic [31:0] oh);
    onehot_to_idx = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) onehot_to_idx = i;
  endfunction

endpackage

// File: rtl/rr_ring_pointer.sv
// One-hot rotating priority pointer. Loading index i moves priority to i+1 (mod N).
module rr_ring_pointer #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  ptr
);

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= N'(1);
    else if (load)
      ptr <= (int'(idx) == N-1) ? N'(1) : (N'(1) << (idx + 1'b1));
  end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with grant-until-release. Define RR_ARB_TIMEOUT_EN to
// build a hold counter that force-releases a grant after TIMEOUT cycles.
module rr_ring_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N       = RR_ARB_DEFAULT_N,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  arb_state_t    state, state_n;
  logic [N-1:0]  ptr;
  logic [N-1:0]  grant_n;
  logic [IW-1:0] id_n, pick_id;
  logic          busy_n, to_n, pick_hit, rel, forced, ptr_load;
  int            p, j;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] cnt, cnt_n;
`endif

  rr_ring_pointer #(.N(N), .IW(IW)) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .load (ptr_load),
    .idx  (grant_id),
    .ptr  (ptr)
  );

  // Circular scan starting at the pointer position.
  always_comb begin
    pick_hit = 1'b0;
    pick_id  = '0;
    j        = 0;
    p        = onehot_to_idx(32'(ptr));
    for (int k = 0; k < N; k++) begin
      j = p + k;
      if (j >= N) j = j - N;
      if (!pick_hit && req[j]) begin
        pick_hit = 1'b1;
        pick_id  = IW'(j);
      end
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    id_n     = grant_id;
    busy_n   = busy;
    to_n     = 1'b0;
    ptr_load = 1'b0;
    rel      = done || !req[grant_id];
    forced   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_n    = cnt;
    forced   = (cnt == CW'(TIMEOUT-1));
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_hit) begin
          state_n = ARB_GRANT;
          grant_n = N'(1) << pick_id;
          id_n    = pick_id;
          busy_n  = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (rel || forced) begin
          state_n  = ARB_IDLE;
          grant_n  = '0;
          id_n     = '0;
          busy_n   = 1'b0;
          ptr_load = 1'b1;
          // A real release in the deadline cycle wins over the timeout.
          to_n     = forced && !rel;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= id_n;
      busy     <= busy_n;
      timeout  <= to_n;
`ifdef RR_ARB_TIMEOUT_EN
      cnt      <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter (N=4, TIMEOUT=16); expectations are hand-computed.
module tb_rr_ring_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  rr_ring_arbiter #(.N(4), .TIMEOUT(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id, input logic b);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".id"}, 32'(grant_id), 32'(id));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    step();
    step();
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.timeout", 32'(timeout), 32'd0);
    chk("reset.ptr", 32'(u_dut.ptr), 32'h1);

    rst = 1'b0;
    step();
    chk_out("first", 4'b0001, 2'd0, 1'b1);

    // Rotation with a one-cycle idle gap between grants
    for (int i = 1; i <= 4; i++) begin
      done = 1'b1;
      step();
      chk_out("rot_gap", 4'b0000, 2'd0, 1'b0);
      done = 1'b0;
      step();
      chk_out("rot", 4'(1 << (i % 4)), 2'(i % 4), 1'b1);
    end

    // Fairness skip: pointer moves to bit 1, only 0 and 3 request
    done = 1'b1;
    req  = 4'b1001;
    step();
    chk("skip.ptr", 32'(u_dut.ptr), 32'h2);
    done = 1'b0;
    step();
    chk_out("skip", 4'b1000, 2'd3, 1'b1);
    done = 1'b1;
    step();
    chk("wrap.ptr", 32'(u_dut.ptr), 32'h1);
    done = 1'b0;
    step();
    chk_out("wrap", 4'b0001, 2'd0, 1'b1);

    // Withdrawal: owner 0 drops, then requester 2 is granted and withdraws
    req = 4'b0100;
    step();
    chk_out("wd0", 4'b0000, 2'd0, 1'b0);
    step();
    chk_out("g2", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    step();
    chk_out("wd2", 4'b0000, 2'd0, 1'b0);
    chk("wd2.ptr", 32'(u_dut.ptr), 32'h8);
    done = 1'b1;
    step();
    chk_out("idle_done", 4'b0000, 2'd0, 1'b0);
    chk("idle_done.ptr", 32'(u_dut.ptr), 32'h8);
    done = 1'b0;

    // Reset mid-grant drops the grant without a pointer update
    req = 4'b0100;
    step();
    chk_out("pre_rst", 4'b0100, 2'd2, 1'b1);
    rst = 1'b1;
    step();
    chk_out("mid_rst", 4'b0000, 2'd0, 1'b0);
    chk("mid_rst.ptr", 32'(u_dut.ptr), 32'h1);
    rst = 1'b0;
    req = 4'b0110;
    step();
    chk_out("post_rst", 4'b0010, 2'd1, 1'b1);
    req = 4'b1111;
    step();
    chk_out("hold", 4'b0010, 2'd1, 1'b1);

    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk_out("g2b", 4'b0100, 2'd2, 1'b1);
`ifdef RR_ARB_TIMEOUT_EN
    // Forced release exactly 16 cycles after the grant rose
    for (int c = 1; c <= 15; c++) begin
      step();
      chk("to.hold", 32'(grant), 32'h4);
      chk("to.quiet", 32'(timeout), 32'd0);
    end
    step();
    chk_out("to.rel", 4'b0000, 2'd0, 1'b0);
    chk("to.pulse", 32'(timeout), 32'd1);
    step();
    chk("to.pulse_end", 32'(timeout), 32'd0);
    chk_out("to.next", 4'b1000, 2'd3, 1'b1);
    for (int c = 1; c <= 15; c++) step();
    done = 1'b1;
    step();
    chk_out("to.done_rel", 4'b0000, 2'd0, 1'b0);
    chk("to.no_pulse", 32'(timeout), 32'd0);
    done = 1'b0;
`else
    // Without the timeout feature the grant is held indefinitely
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c % 5 == 0) begin
        chk("nto.hold", 32'(grant), 32'h4);
        chk("nto.quiet", 32'(timeout), 32'd0);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
